// File: rtl/i2c_xfer_seq.sv
// Register-level transfer sequencer for a byte-oriented I2C master core.
// Walks address/register/data phases, evaluates master status, and recovers from NACK, error and timeout.
module i2c_xfer_seq #(
    parameter int TMO = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rnw,
    input  logic [6:0] dev,
    input  logic [7:0] reg_addr,
    input  logic [1:0] len,
    input  logic [7:0] wdat,
    output logic       wtake,
    output logic [7:0] rdat,
    output logic       rvalid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       nack,
    output logic [4:0] m_cmd,
    output logic [7:0] m_dat,
    output logic       m_ws,
    input  logic [3:0] m_stat,
    input  logic [7:0] m_rdat
);

    localparam int TW = (TMO < 4) ? 2 : $clog2(TMO + 1);

    localparam logic [4:0] C_STRT = 5'h01;
    localparam logic [4:0] C_STOP = 5'h02;
    localparam logic [4:0] C_READ = 5'h04;
    localparam logic [4:0] C_WRTE = 5'h08;
    localparam logic [4:0] C_NACK = 5'h10;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACC, S_WAIT_DONE, S_EVAL, S_STOP_ONLY, S_CLRS, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        P_ADDRW, P_REG, P_WDATA, P_ADDRR, P_RDATA
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rnw_q, rnw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic          stop_q, stop_d;
    logic          err_q, err_d;
    logic          nack_q, nack_d;
    logic [4:0]    cmd_q, cmd_d;
    logic [7:0]    dat_q, dat_d;
    logic [7:0]    rdat_q, rdat_d;
    logic [4:0]    issue_cmd;
    logic [7:0]    issue_dat;

    // Arbitration loss is treated the same as a reported master error.
    logic st_bsy, st_err, st_ack, last_byte;
    assign st_bsy    = m_stat[0];
    assign st_err    = m_stat[1] | m_stat[2];
    assign st_ack    = m_stat[3];
    assign last_byte = (cnt_q == 2'd0);

    always_comb begin
        issue_cmd = 5'h00;
        issue_dat = 8'h00;
        if (stop_q) begin
            issue_cmd = C_STOP;
        end else begin
            case (phase_q)
                P_ADDRW: begin issue_cmd = C_STRT | C_WRTE; issue_dat = {dev_q, 1'b0}; end
                P_REG:   begin issue_cmd = C_WRTE;          issue_dat = reg_q;         end
                P_WDATA: begin
                    issue_cmd = last_byte ? (C_WRTE | C_STOP) : C_WRTE;
                    issue_dat = wdat;
                end
                P_ADDRR: begin issue_cmd = C_STRT | C_WRTE; issue_dat = {dev_q, 1'b1}; end
                P_RDATA: begin
                    issue_cmd = last_byte ? (C_READ | C_NACK | C_STOP) : C_READ;
                    issue_dat = 8'hFF;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        stop_d  = stop_q;
        err_d   = err_q;
        nack_d  = nack_q;
        rdat_d  = rdat_q;
        cmd_d   = cmd_q;
        dat_d   = dat_q;
        m_ws    = 1'b0;
        wtake   = 1'b0;
        rvalid  = 1'b0;
        rdat    = rdat_q;
        done    = 1'b0;

        case (state_q)
            S_IDLE: if (req) begin
                rnw_d   = rnw;
                dev_d   = dev;
                reg_d   = reg_addr;
                cnt_d   = len;
                err_d   = 1'b0;
                nack_d  = 1'b0;
                stop_d  = 1'b0;
                phase_d = P_ADDRW;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_d   = issue_cmd;
                dat_d   = issue_dat;
                m_ws    = 1'b1;
                wtake   = (phase_q == P_WDATA) && !stop_q;
                state_d = S_WAIT_ACC;
            end
            S_WAIT_ACC: begin
                if (st_err)                 state_d = S_EVAL;
                else if (st_bsy)            state_d = S_WAIT_DONE;
                else if (tmo_q == '0) begin err_d = 1'b1; nack_d = 1'b0; state_d = S_CLRS; end
            end
            S_WAIT_DONE: begin
                if (!st_bsy)                state_d = S_EVAL;
                else if (tmo_q == '0) begin err_d = 1'b1; nack_d = 1'b0; state_d = S_CLRS; end
            end
            S_EVAL: begin
                if (st_err) begin
                    err_d   = 1'b1;
                    nack_d  = 1'b0;
                    state_d = S_CLRS;
                end else if (stop_q) begin
                    state_d = S_DONE;
                end else if (cmd_q[3] && !st_ack) begin
                    err_d   = 1'b1;
                    nack_d  = 1'b1;
                    state_d = cmd_q[1] ? S_DONE : S_STOP_ONLY;
                end else begin
                    state_d = S_ISSUE;
                    case (phase_q)
                        P_ADDRW: phase_d = P_REG;
                        P_REG:   phase_d = rnw_q ? P_ADDRR : P_WDATA;
                        P_ADDRR: phase_d = P_RDATA;
                        default: begin
                            if (phase_q == P_RDATA) begin
                                rvalid = 1'b1;
                                rdat   = m_rdat;
                                rdat_d = m_rdat;
                            end
                            if (last_byte) state_d = S_DONE;
                            else           cnt_d   = cnt_q - 2'd1;
                        end
                    endcase
                end
            end
            S_STOP_ONLY: begin
                stop_d  = 1'b1;
                state_d = S_ISSUE;
            end
            S_CLRS: begin
                if (tmo_q == TW'(2)) begin
                    cmd_d = 5'h00;
                    dat_d = 8'h00;
                    m_ws  = 1'b1;
                end
                if (tmo_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The same down-counter times the wait states and the CLRS settle interval.
        if (state_d != state_q)  tmo_d = (state_d == S_CLRS) ? TW'(2) : TW'(TMO - 1);
        else if (tmo_q != '0)    tmo_d = tmo_q - TW'(1);
        else                     tmo_d = tmo_q;
    end

    assign m_cmd = cmd_d;
    assign m_dat = dat_d;
    assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign err   = err_q;
    assign nack  = nack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= P_ADDRW;
            cnt_q   <= 2'd0;
            tmo_q   <= '0;
            rnw_q   <= 1'b0;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            nack_q  <= 1'b0;
            cmd_q   <= 5'h00;
            dat_q   <= 8'h00;
            rdat_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            rnw_q   <= rnw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            nack_q  <= nack_d;
            cmd_q   <= cmd_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
        end
    end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Bench for i2c_xfer_seq: a responding master model, a command-list reference model,
// a vector table of directed transfers, random transfers and reset/timeout sequences.
module tb_i2c_xfer_seq;

    logic       clk = 1'b0;
    logic       rst, req, rnw;
    logic [6:0] dev;
    logic [7:0] reg_addr, wdat, rdat, m_dat, m_rdat;
    logic [1:0] len;
    logic       wtake, rvalid, busy, done, err, nack, m_ws;
    logic [4:0] m_cmd;
    logic [3:0] m_stat;

    always #5 clk = ~clk;

    i2c_xfer_seq #(.TMO(16)) dut (
        .clk(clk), .rst(rst), .req(req), .rnw(rnw), .dev(dev), .reg_addr(reg_addr),
        .len(len), .wdat(wdat), .wtake(wtake), .rdat(rdat), .rvalid(rvalid),
        .busy(busy), .done(done), .err(err), .nack(nack), .m_cmd(m_cmd),
        .m_dat(m_dat), .m_ws(m_ws), .m_stat(m_stat), .m_rdat(m_rdat)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // master/slave behaviour for the current transfer
    int          err_at, nack_at, hang_at;
    logic [31:0] wbytes_g, rbytes_g;
    int          cmd_idx, rd_idx, wi;

    // observed activity
    logic [4:0] log_cmd[$];
    logic [7:0] log_dat[$];
    int         log_cyc[$];
    logic [7:0] got_rd[$];
    int         done_cnt, wt_cnt, cyc;
    logic       got_err, got_nack;

    // expected activity
    logic [4:0] exp_cmd[$];
    logic [7:0] exp_dat[$];
    bit         exp_dchk[$];
    logic [7:0] exp_rd[$];
    logic       exp_err, exp_nack;
    int         exp_wt;

    int         mode, rcnt;
    logic       r_err, r_ack;
    logic [7:0] r_rdat;

    // Master model and monitor: acknowledges each strobe, then reports busy and final status.
    initial begin
        m_stat = 4'h0; m_rdat = 8'h00; mode = 0; cyc = 0; rcnt = 0;
        r_err = 1'b0; r_ack = 1'b1; r_rdat = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mode = 0; m_stat = 4'h0;
            end else begin
                if (done) begin done_cnt++; got_err = err; got_nack = nack; end
                if (rvalid) got_rd.push_back(rdat);
                if (wtake) wt_cnt++;
                if (m_ws) begin
                    log_cmd.push_back(m_cmd);
                    log_dat.push_back(m_dat);
                    log_cyc.push_back(cyc);
                    m_stat = 4'h0;
                    mode = 0;
                    if (m_cmd != 5'h00) begin
                        r_err = (cmd_idx == err_at);
                        r_ack = (cmd_idx != nack_at);
                        if (m_cmd[2] && rd_idx < 4) begin
                            r_rdat = rbytes_g[8*rd_idx +: 8];
                            rd_idx++;
                        end
                        if (cmd_idx != hang_at) begin
                            mode = 1; rcnt = $urandom_range(0, 2);
                        end
                        cmd_idx++;
                    end
                    if (wtake) begin
                        wi++;
                        if (wi < 4) wdat = wbytes_g[8*wi +: 8];
                    end
                end else if (mode == 1) begin
                    if (rcnt == 0) begin
                        if (r_err) begin m_stat = 4'h6; mode = 0; end
                        else begin m_stat = 4'h1; rcnt = $urandom_range(0, 3); mode = 2; end
                    end else rcnt--;
                end else if (mode == 2) begin
                    if (rcnt == 0) begin
                        m_stat = r_ack ? 4'h8 : 4'h0;
                        m_rdat = r_rdat;
                        mode = 0;
                    end else rcnt--;
                end
            end
        end
    end

    // Reference: the command list the transfer should produce, cut short at the first fault.
    task automatic model(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [1:0] l,
                         input logic [31:0] wb, input logic [31:0] rb, input int ea, input int na, input int ha);
        logic [4:0] c[$];
        logic [7:0] dd[$];
        bit         wd[$];
        logic [4:0] ck;
        int         ri;
        exp_cmd.delete(); exp_dat.delete(); exp_dchk.delete(); exp_rd.delete();
        exp_err = 1'b0; exp_nack = 1'b0; exp_wt = 0; ri = 0;
        c.push_back(5'h09); dd.push_back({d, 1'b0}); wd.push_back(0);
        c.push_back(5'h08); dd.push_back(ra);        wd.push_back(0);
        if (!r) begin
            for (int i = 0; i <= int'(l); i++) begin
                c.push_back((i == int'(l)) ? 5'h0A : 5'h08); dd.push_back(wb[8*i +: 8]); wd.push_back(1);
            end
        end else begin
            c.push_back(5'h09); dd.push_back({d, 1'b1}); wd.push_back(0);
            for (int i = 0; i <= int'(l); i++) begin
                c.push_back((i == int'(l)) ? 5'h16 : 5'h04); dd.push_back(8'hFF); wd.push_back(0);
            end
        end
        for (int k = 0; k < c.size(); k++) begin
            ck = c[k];
            exp_cmd.push_back(ck); exp_dat.push_back(dd[k]); exp_dchk.push_back(1);
            if (wd[k]) exp_wt++;
            if (k == ea || k == ha) begin
                exp_cmd.push_back(5'h00); exp_dat.push_back(8'h00); exp_dchk.push_back(0);
                exp_err = 1'b1; exp_nack = 1'b0;
                return;
            end
            if (ck[3] && k == na) begin
                exp_err = 1'b1; exp_nack = 1'b1;
                if (!ck[1]) begin
                    exp_cmd.push_back(5'h02); exp_dat.push_back(8'h00); exp_dchk.push_back(0);
                end
                return;
            end
            if (ck[2]) begin
                exp_rd.push_back(rb[8*ri +: 8]);
                ri++;
            end
        end
    endtask

    task automatic start_txn(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [1:0] l,
                             input logic [31:0] wb, input logic [31:0] rb, input int ea, input int na, input int ha);
        err_at = ea; nack_at = na; hang_at = ha;
        wbytes_g = wb; rbytes_g = rb;
        cmd_idx = 0; rd_idx = 0; wi = 0;
        log_cmd.delete(); log_dat.delete(); log_cyc.delete(); got_rd.delete();
        done_cnt = 0; wt_cnt = 0;
        @(negedge clk);
        rnw = r; dev = d; reg_addr = ra; len = l; wdat = wb[7:0]; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic r, input logic [6:0] d, input logic [7:0] ra,
                           input logic [1:0] l, input logic [31:0] wb, input logic [31:0] rb,
                           input int ea, input int na, input int ha, input bit poke);
        model(r, d, ra, l, wb, rb, ea, na, ha);
        start_txn(r, d, ra, l, wb, rb, ea, na, ha);
        for (int n = 0; n < 600 && done_cnt == 0; n++) begin
            @(negedge clk);
            req = (poke && n == 4 && busy);
        end
        req = 1'b0;
        repeat (6) @(negedge clk);
        chk($sformatf("%s done_cnt", tag), done_cnt, 1);
        chk($sformatf("%s busy_after", tag), busy, 0);
        chk($sformatf("%s ncmd", tag), log_cmd.size(), exp_cmd.size());
        for (int i = 0; i < log_cmd.size() && i < exp_cmd.size(); i++) begin
            chk($sformatf("%s cmd%0d", tag, i), log_cmd[i], exp_cmd[i]);
            if (exp_dchk[i]) chk($sformatf("%s dat%0d", tag, i), log_dat[i], exp_dat[i]);
        end
        chk($sformatf("%s nrd", tag), got_rd.size(), exp_rd.size());
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            chk($sformatf("%s rd%0d", tag, i), got_rd[i], exp_rd[i]);
        chk($sformatf("%s err", tag), got_err, exp_err);
        chk($sformatf("%s nack", tag), got_nack, exp_nack);
        chk($sformatf("%s wtake", tag), wt_cnt, exp_wt);
    endtask

    typedef struct {
        logic        rnw;
        logic [6:0]  dev;
        logic [7:0]  ra;
        logic [1:0]  len;
        logic [31:0] wb;
        logic [31:0] rb;
        int          ea;
        int          na;
        int          exp_n;
        logic        exp_err;
        logic        exp_nack;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic       r;
        logic [1:0] l;
        int         ncm, f, ea, na, nlog, gap;

        vt[0] = '{1'b0, 7'h3B, 8'h10, 2'd0, 32'h000000A5, 32'h0,        -1, -1, 3, 1'b0, 1'b0};
        vt[1] = '{1'b1, 7'h3B, 8'h10, 2'd1, 32'h0,        32'h00005655, -1, -1, 5, 1'b0, 1'b0};
        vt[2] = '{1'b0, 7'h22, 8'h10, 2'd0, 32'h00000011, 32'h0,        -1,  0, 2, 1'b1, 1'b1};
        vt[3] = '{1'b0, 7'h3B, 8'h10, 2'd0, 32'h000000A5, 32'h0,         1, -1, 3, 1'b1, 1'b0};
        vt[4] = '{1'b0, 7'h3B, 8'h20, 2'd3, 32'h44332211, 32'h0,        -1,  5, 6, 1'b1, 1'b1};
        vt[5] = '{1'b0, 7'h3B, 8'h20, 2'd2, 32'h00332211, 32'h0,        -1,  1, 3, 1'b1, 1'b1};
        vt[6] = '{1'b1, 7'h50, 8'h01, 2'd0, 32'h0,        32'h000000AB, -1,  3, 4, 1'b0, 1'b0};
        vt[7] = '{1'b1, 7'h50, 8'h01, 2'd2, 32'h0,        32'h00C3B2A1, -1,  2, 4, 1'b1, 1'b1};
        vt[8] = '{1'b1, 7'h7F, 8'hFF, 2'd3, 32'h0,        32'h44332211, -1, -1, 7, 1'b0, 1'b0};
        vt[9] = '{1'b1, 7'h12, 8'h34, 2'd1, 32'h0,        32'h00009988,  3, -1, 5, 1'b1, 1'b0};

        rst = 1'b1; req = 1'b0; rnw = 1'b0; dev = 7'h00; reg_addr = 8'h00; len = 2'd0; wdat = 8'h00;
        err_at = -1; nack_at = -1; hang_at = -1; wbytes_g = 0; rbytes_g = 0;
        cmd_idx = 0; rd_idx = 0; wi = 0; done_cnt = 0; wt_cnt = 0; got_err = 1'b0; got_nack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, err, nack, rvalid, wtake, m_ws, m_cmd, m_dat, rdat}, 0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_txn($sformatf("vec%0d", v), vt[v].rnw, vt[v].dev, vt[v].ra, vt[v].len,
                    vt[v].wb, vt[v].rb, vt[v].ea, vt[v].na, -1, 1'b0);
            chk($sformatf("vec%0d tbl_ncmd", v), log_cmd.size(), vt[v].exp_n);
            chk($sformatf("vec%0d tbl_err", v), got_err, vt[v].exp_err);
            chk($sformatf("vec%0d tbl_nack", v), got_nack, vt[v].exp_nack);
        end

        // master never responds to the REG byte: timeout then CLRS
        run_txn("tmo", 1'b0, 7'h3B, 8'h10, 2'd0, 32'hA5, 32'h0, -1, -1, 1, 1'b0);
        gap = (log_cyc.size() >= 3) ? (log_cyc[2] - log_cyc[1]) : 0;
        chk("tmo_gap_in_window", (gap >= 16 && gap <= 18), 1);

        // reset in the middle of the write data phase
        start_txn(1'b0, 7'h3B, 8'h10, 2'd3, 32'h44332211, 32'h0, -1, -1, -1);
        for (int n = 0; n < 300 && wt_cnt == 0; n++) @(negedge clk);
        chk("mid_rst wtake_seen", wt_cnt, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst outputs", {busy, done, err, nack, rvalid, wtake, m_ws, m_cmd, m_dat, rdat}, 0);
        rst = 1'b0;
        nlog = log_cmd.size();
        done_cnt = 0;
        repeat (40) @(negedge clk);
        chk("mid_rst no_ws", log_cmd.size(), nlog);
        chk("mid_rst no_done", done_cnt, 0);
        run_txn("after_rst", vt[0].rnw, vt[0].dev, vt[0].ra, vt[0].len, vt[0].wb, vt[0].rb, -1, -1, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            r   = 1'($urandom_range(0, 1));
            l   = 2'($urandom_range(0, 3));
            ncm = r ? int'(l) + 4 : int'(l) + 3;
            f   = int'($urandom_range(0, 3));
            ea  = (f == 3) ? int'($urandom_range(0, ncm - 1)) : -1;
            na  = (f == 2) ? int'($urandom_range(0, ncm - 1)) : -1;
            run_txn($sformatf("rnd%0d", t), r, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), l,
                    $urandom, $urandom, ea, na, -1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 SHALL have parameter TMO, default 20000: cycles allowed in any master wait state before timeout abort.
REQ-002 SHALL have ports as listed (name  direction  width  meaning):
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  reset, synchronous, active-high
  req  in  1  start transfer; sampled only in IDLE
  rnw  in  1  1 = register read, 0 = register write
  dev  in  7  7-bit slave address
  reg_addr  in  8  register/sub-address byte
  len  in  2  byte count minus one (1..4 bytes)
  wdat  in  8  write data byte
  wtake  out  1  one-cycle pulse: current wdat consumed; next byte valid by the following cycle
  rdat  out  8  read data byte
  rvalid  out  1  one-cycle pulse: rdat valid
  busy  out  1  transfer in progress
  done  out  1  one-cycle pulse: transfer finished (ok or error)
  err  out  1  last transfer failed; valid with done, held until next req
  nack  out  1  last failure was slave NACK; valid with done
  m_cmd  out  5  master command: bit0 STRT, bit1 STOP, bit2 READ, bit3 WRTE, bit4 NACK
  m_dat  out  8  master write byte
  m_ws  out  1  master command strobe
  m_stat  in  4  master status: bit0 BSY, bit1 ERR, bit2 ALO, bit3 ACK
  m_rdat  in  8  master read byte

Function
REQ-003 SHALL use states IDLE, ISSUE, WAIT_ACC, WAIT_DONE, EVAL, STOP_ONLY, CLRS, DONE, plus a step counter for phases ADDRW, REG, WDATA, ADDRR, RDATA.
REQ-004 IDLE: on req=1, SHALL latch rnw/dev/reg_addr/len, clear err/nack, assert busy, and go to ISSUE with phase ADDRW.
REQ-005 ISSUE SHALL drive m_cmd/m_dat and pulse m_ws for exactly one cycle; m_cmd/m_dat SHALL be held stable until WAIT_DONE exits.
REQ-006 Phase commands SHALL be: ADDRW = STRT|WRTE, {dev,0}; REG = WRTE, reg_addr; WDATA = WRTE, wdat (STOP added on last byte); ADDRR = STRT|WRTE, {dev,1}; RDATA = READ (NACK|STOP added on last byte), m_dat=0xFF.
REQ-007 Write sequence SHALL be ADDRW, REG, WDATA x(len+1); read sequence SHALL be ADDRW, REG, ADDRR, RDATA x(len+1).
REQ-008 wtake SHALL pulse in the ISSUE cycle of each WDATA byte.
REQ-009 WAIT_ACC SHALL wait for m_stat.BSY=1 or m_stat.ERR=1; WAIT_DONE SHALL wait for BSY=0; both SHALL then go to EVAL.
REQ-010 EVAL with ERR=1 SHALL go to CLRS with err=1 and nack=0, and SHALL NOT issue a STOP (covers ALO and sanity errors).
REQ-011 EVAL after a WRTE phase with ACK=0 SHALL set err=1 and nack=1; SHALL go to STOP_ONLY unless that command already carried STOP, in which case it SHALL go to DONE.
REQ-012 EVAL after RDATA SHALL copy m_rdat to rdat and pulse rvalid the same cycle; ACK SHALL be ignored for reads.
REQ-013 EVAL with no failure SHALL advance the phase; after the final phase it SHALL go to DONE, otherwise to ISSUE.
REQ-014 STOP_ONLY SHALL issue m_cmd=STOP via the ISSUE/WAIT path and then go to DONE regardless of status; if that STOP returns ERR, it SHALL go to CLRS instead.
REQ-015 CLRS SHALL issue m_cmd=0 with one m_ws pulse, wait 2 cycles, and then go to DONE.
REQ-016 A timeout counter SHALL reset on each state entry; reaching TMO in WAIT_ACC/WAIT_DONE SHALL set err=1 and nack=0 and go to CLRS.
REQ-017 DONE SHALL pulse done for one cycle, deassert busy, and return to IDLE; req during busy SHALL be ignored.
REQ-018 Byte counter SHALL be 2 bits and count len down to 0 with no wrap; len=0 SHALL give exactly one data byte.

Reset
REQ-019 With rst=1 at a clock edge, the next state SHALL be IDLE, and busy, done, err, nack, rvalid, wtake, m_ws SHALL be 0, m_cmd=0, m_dat=0, rdat=0.
REQ-020 Reset mid-transfer SHALL abort immediately with no STOP or CLRS issued and no done pulse.

Verification
REQ-021 Write, dev=0x3B, reg_addr=0x10, len=0, wdat=0xA5, slave ACKs -> m_cmd/m_dat sequence 0x09/0x76, 0x08/0x10, 0x0A/0xA5; one wtake; done with err=0.
REQ-022 Read, dev=0x3B, reg_addr=0x10, len=1, slave returns 0x55 then 0x56 -> commands 0x09/0x76, 0x08/0x10, 0x09/0x77, 0x04, 0x16; rvalid twice with rdat 0x55 then 0x56; err=0.
REQ-023 Address NACK with dev=0x22 -> after the first command, m_cmd=0x02 is issued alone; done with err=1, nack=1; no REG phase.
REQ-024 Master reports ERR|ALO during REG -> m_cmd=0x00 CLRS issued, no STOP; done with err=1, nack=0.
REQ-025 m_stat held at 0 after m_ws, with TMO=16 -> CLRS after 16 cycles; done with err=1.
REQ-026 rst asserted during WDATA -> busy=0 next cycle, no further m_ws, no done; a new req then runs normally.
